pulse_updown_counter: RTL and testbench
=======================================

Name: pulse_updown_counter

Overview:
- Downstream consumer of the two-sensor direction FSM.
- Turns its one-cycle inc/dec event outputs into a bounded up/down tally, e.g. catches/score or occupancy.
- Count saturates at 0 and MAX_COUNT, exposes boundary flags and event pulses, and feeds the display/score logic.
- Inputs are rising-edge qualified, so a held inc/dec level counts exactly once.

Parameters:
WIDTH, 4, count register width
MAX_COUNT, 9, upper saturation value; must satisfy 0 < MAX_COUNT <= 2^WIDTH-1
INIT, 0, value loaded on reset and on clear; must be <= MAX_COUNT

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous reload of count to INIT
inc  input  1  increment request from direction FSM (level; rising edge counted)
dec  input  1  decrement request from direction FSM (level; rising edge counted)
count  output  WIDTH  current tally, registered
at_max  output  1  count == MAX_COUNT, registered
at_zero  output  1  count == 0, registered
changed  output  1  one-cycle pulse, count changed this edge
ovf  output  1  one-cycle pulse, inc rejected at MAX_COUNT
unf  output  1  one-cycle pulse, dec rejected at 0

Behaviour:
- Reset (async):
  - count = INIT; at_max = (INIT == MAX_COUNT); at_zero = (INIT == 0).
  - changed = ovf = unf = 0; inc_q = dec_q = 0.
- Edge detect:
  - inc_q/dec_q register the previous inc/dec.
  - inc_rise = inc & ~inc_q; dec_rise = dec & ~dec_q.
  - Reset clears inc_q/dec_q, so inc already high at the first edge after reset counts once.
- Latency: an event sampled at edge N is reflected in count, flags and pulses immediately after edge N.
- Priority per edge, highest first:
  - clear: count <= INIT; changed = 1 iff count != INIT; ovf = unf = 0; pending rises are discarded, but inc_q/dec_q still update.
  - inc_rise & dec_rise together: no change, all pulses 0.
  - inc_rise: if count < MAX_COUNT, count + 1 and changed = 1; else count holds and ovf = 1.
  - dec_rise: if count > 0, count - 1 and changed = 1; else count holds and unf = 1.
  - Otherwise: hold, all pulses 0.
- Pulses are high for exactly one cycle and never coincide pairwise.
- No wrap-around ever; arithmetic is WIDTH bits and guarded by the comparisons above.
- at_max/at_zero are derived from the next count and registered, so they are never stale by a cycle.
- A held inc/dec level produces no further events until it drops and rises again.
- Reset asserted mid-event aborts it; state returns to reset values.

Optional Feature:
- BCD_OUT_EN defined:
  - Adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered decimal digits of the next count, so they update on the same edge as count.
  - Reset value is the BCD of INIT.
  - Requires MAX_COUNT <= 99; elaboration error otherwise.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: event-priority encoding constant, and a function returning next count for (count, inc_rise, dec_rise, clear).
- With BCD_OUT_EN, the package also holds the BCD conversion function.
- One sub-module: rise_detect (clk, reset, d -> rise), instantiated twice, for inc and dec.

Test Plan:
- Reset, INIT=0, MAX_COUNT=9 -> count=0, at_zero=1, at_max=0, all pulses 0.
- Five 1-cycle inc pulses -> count=5, five changed pulses; inc held high 10 cycles -> count +1 only.
- From count=9, inc pulse -> count stays 9, ovf=1 for one cycle, at_max=1; from count=0, dec pulse -> unf=1, count stays 0.
- inc and dec rise on the same edge at count=4 -> count=4, no pulses; clear with inc rise at count=7 -> count=0, changed=1, ovf=0.
- Reset asserted asynchronously mid-cycle at count=6 -> count=0 immediately; inc high across reset release -> count=1 after first edge.
- BCD_OUT_EN with MAX_COUNT=99 at count=57 -> bcd_tens=5, bcd_ones=7; one inc -> 5/8 on the same edge as count=58.

Source files
------------

// File: rtl/pulse_updown_counter_pkg.sv
// Shared definitions for the pulse up/down counter: the per-edge event
// priority encoding, the next-count function and, when BCD_OUT_EN is
// defined, the binary-to-BCD digit conversion.
package pulse_updown_counter_pkg;

    // Events a single clock edge can carry, resolved in priority order:
    // clear beats simultaneous inc/dec, which beats a lone inc or dec.
    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_CLEAR = 3'd1,
        EV_BOTH  = 3'd2,
        EV_INC   = 3'd3,
        EV_DEC   = 3'd4
    } event_e;

    // Resolve clear and the two rise strobes into one prioritised event.
    function automatic event_e classify_event(input logic clr,
                                              input logic incRise,
                                              input logic decRise);
        event_e ev;
        if (clr)                     ev = EV_CLEAR;
        else if (incRise && decRise) ev = EV_BOTH;
        else if (incRise)            ev = EV_INC;
        else if (decRise)            ev = EV_DEC;
        else                         ev = EV_NONE;
        return ev;
    endfunction

    // Next tally for one edge. Saturates at 0 and maxVal, so the result
    // never wraps regardless of the register width it is stored in.
    function automatic int unsigned next_count(input int unsigned cnt,
                                               input logic        incRise,
                                               input logic        decRise,
                                               input logic        clr,
                                               input int unsigned initVal,
                                               input int unsigned maxVal);
        int unsigned nxt;
        nxt = cnt;
        case (classify_event(clr, incRise, decRise))
            EV_CLEAR: nxt = initVal;
            EV_INC:   if (cnt < maxVal) nxt = cnt + 1;
            EV_DEC:   if (cnt > 0)      nxt = cnt - 1;
            default:  nxt = cnt;
        endcase
        return nxt;
    endfunction

`ifdef BCD_OUT_EN
    // Two decimal digits {tens, ones} of a value known to be at most 99.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction
`endif

endpackage

// File: rtl/pulse_updown_counter_rise_detect.sv
// Rising-edge qualifier: turns a level request into a single-cycle strobe on
// the cycle where the level first goes high. Reset clears the history, so a
// level already high at the first edge after reset is seen as a rise.
module pulse_updown_counter_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic dQ;

    // Remember the level sampled on the previous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dQ <= 1'b0;
        else       dQ <= d;
    end

    assign rise = d & ~dQ;

endmodule

// File: rtl/pulse_updown_counter.sv
// Bounded up/down tally fed by one-cycle inc/dec events from the direction
// FSM. Saturates at 0 and MAX_COUNT, reports boundary flags and one-cycle
// changed/overflow/underflow pulses, all registered.
// Optional feature macro: BCD_OUT_EN adds registered decimal digit outputs
// bcd_tens/bcd_ones (requires MAX_COUNT <= 99).
module pulse_updown_counter
    import pulse_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 9,
    parameter int unsigned INIT      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             changed,
    output logic             ovf,
    output logic             unf
`ifdef BCD_OUT_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    localparam logic [WIDTH-1:0] MaxCount  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] InitCount = WIDTH'(INIT);

    // Reject parameter sets that would let the tally exceed its register.
    if (MAX_COUNT == 0 || (64'(MAX_COUNT) >> WIDTH) != 64'd0) begin : gen_bad_max
        $error("pulse_updown_counter: MAX_COUNT must be in 1..2^WIDTH-1");
    end
    if (INIT > MAX_COUNT) begin : gen_bad_init
        $error("pulse_updown_counter: INIT must not exceed MAX_COUNT");
    end
`ifdef BCD_OUT_EN
    if (MAX_COUNT > 99) begin : gen_bad_bcd
        $error("pulse_updown_counter: BCD output needs MAX_COUNT <= 99");
    end
`endif

    logic             incRise;
    logic             decRise;
    event_e           ev;
    logic [WIDTH-1:0] countD, countQ;
    logic             atMaxD, atMaxQ;
    logic             atZeroD, atZeroQ;
    logic             changedD, changedQ;
    logic             ovfD, ovfQ;
    logic             unfD, unfQ;

    pulse_updown_counter_rise_detect u_inc_rise (
        .clk   (clk),
        .reset (reset),
        .d     (inc),
        .rise  (incRise)
    );

    pulse_updown_counter_rise_detect u_dec_rise (
        .clk   (clk),
        .reset (reset),
        .d     (dec),
        .rise  (decRise)
    );

    // Next tally, flags and pulses; flags come from the next count so they
    // land on the same edge as the count itself.
    always_comb begin
        ev       = classify_event(clear, incRise, decRise);
        countD   = WIDTH'(next_count(32'(countQ), incRise, decRise, clear,
                                     INIT, MAX_COUNT));
        atMaxD   = (countD == MaxCount);
        atZeroD  = (countD == '0);
        changedD = (countD != countQ);
        ovfD     = (ev == EV_INC) && (countQ == MaxCount);
        unfD     = (ev == EV_DEC) && (countQ == '0);
    end

    // Register the tally, boundary flags and event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countQ   <= InitCount;
            atMaxQ   <= (INIT == MAX_COUNT);
            atZeroQ  <= (INIT == 0);
            changedQ <= 1'b0;
            ovfQ     <= 1'b0;
            unfQ     <= 1'b0;
        end else begin
            countQ   <= countD;
            atMaxQ   <= atMaxD;
            atZeroQ  <= atZeroD;
            changedQ <= changedD;
            ovfQ     <= ovfD;
            unfQ     <= unfD;
        end
    end

    assign count   = countQ;
    assign at_max  = atMaxQ;
    assign at_zero = atZeroQ;
    assign changed = changedQ;
    assign ovf     = ovfQ;
    assign unf     = unfQ;

`ifdef BCD_OUT_EN
    logic [7:0] bcdD, bcdQ;

    // Decimal digits of the next count, so the display tracks count exactly.
    always_comb begin
        bcdD = to_bcd(32'(countD));
    end

    // Register the digits alongside the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bcdQ <= to_bcd(INIT);
        else       bcdQ <= bcdD;
    end

    assign bcd_tens = bcdQ[7:4];
    assign bcd_ones = bcdQ[3:0];
`endif

endmodule

// File: tb/tb_pulse_updown_counter.sv
// Directed-vector bench for pulse_updown_counter with WIDTH=4, MAX_COUNT=9,
// INIT=0. Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pulse_updown_counter;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       inc;
    logic       dec;
    logic [3:0] count;
    logic       at_max;
    logic       at_zero;
    logic       changed;
    logic       ovf;
    logic       unf;
`ifdef BCD_OUT_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
`endif

    int compared   = 0;
    int mismatched = 0;

    pulse_updown_counter #(
        .WIDTH     (4),
        .MAX_COUNT (9),
        .INIT      (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .inc     (inc),
        .dec     (dec),
        .count   (count),
        .at_max  (at_max),
        .at_zero (at_zero),
        .changed (changed),
        .ovf     (ovf),
        .unf     (unf)
`ifdef BCD_OUT_EN
        ,
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones)
`endif
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if the DUT disagrees.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic applyStimulus(input logic c, input logic i, input logic d);
        clear = c;
        inc   = i;
        dec   = d;
        @(posedge clk);
        #1;
    endtask

    // Full snapshot check of count, flags and pulses.
    task automatic checkAll(input string tag, input int expCount, input int expChanged,
                            input int expOvf, input int expUnf);
        checkOutput({tag, ".count"},   int'(count),   expCount);
        checkOutput({tag, ".at_max"},  int'(at_max),  int'(expCount == 9));
        checkOutput({tag, ".at_zero"}, int'(at_zero), int'(expCount == 0));
        checkOutput({tag, ".changed"}, int'(changed), expChanged);
        checkOutput({tag, ".ovf"},     int'(ovf),     expOvf);
        checkOutput({tag, ".unf"},     int'(unf),     expUnf);
`ifdef BCD_OUT_EN
        checkOutput({tag, ".bcd_tens"}, int'(bcd_tens), expCount / 10);
        checkOutput({tag, ".bcd_ones"}, int'(bcd_ones), expCount % 10);
`endif
    endtask

    // Single-cycle inc pulse followed by one idle cycle.
    task automatic incPulse(input string tag, input int expCount, input int expChanged,
                            input int expOvf);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll(tag, expCount, expChanged, expOvf, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll({tag, "_idle"}, expCount, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0);
        #3 reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("post_reset", 0, 0, 0, 0);

        // Five separate pulses count up to five.
        for (int n = 1; n <= 5; n++) incPulse("inc_pulse", n, 1, 0);

        // A level held for ten cycles counts once.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("hold_first", 6, 1, 0, 0);
        for (int n = 0; n < 9; n++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("hold_end", 6, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Climb to the top and push past it.
        incPulse("to7", 7, 1, 0);
        incPulse("to8", 8, 1, 0);
        incPulse("to9", 9, 1, 0);
        incPulse("ovf", 9, 0, 1);

        // Clear from 9, then underflow at zero.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAll("clear9", 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAll("unf", 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("unf_idle", 0, 0, 0, 0);

        // Simultaneous inc and dec rises at 4 cancel out.
        for (int n = 1; n <= 4; n++) incPulse("to4", n, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkAll("both", 4, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAll("dec_to3", 3, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Clear wins over an inc rise; the swallowed rise is not replayed.
        for (int n = 4; n <= 7; n++) incPulse("to7b", n, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkAll("clear_inc", 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("after_clear_held", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAll("clear_at_init", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle at 6, inc held across release.
        for (int n = 1; n <= 6; n++) incPulse("to6", n, 1, 0);
        #2 reset = 1'b1;
        #1;
        checkAll("async_reset", 0, 0, 0, 0);
        inc = 1'b1;
        #1 reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("inc_across_reset", 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("inc_across_hold", 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAll("dec_to0", 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
